// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-thread PC holder and round-robin icache fetch sequencer
module pc_sequencer #(
  parameter int          PC_W     = 32,
  parameter int          NTHREAD  = 2,
  parameter int unsigned PC_INIT  = 0,
  parameter int unsigned T_STRIDE = 'h1000,
  parameter int unsigned INCR     = 4,
  localparam int         TID_W    = (NTHREAD > 1) ? $clog2(NTHREAD) : 1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    stall,
  input  logic                    ihit,
  input  logic                    redirect_en,
  input  logic [TID_W-1:0]        redirect_tid,
  input  logic [PC_W-1:0]         redirect_pc,
  input  logic                    halt_en,
  input  logic [TID_W-1:0]        halt_tid,
  output logic                    iREN,
  output logic [PC_W-1:0]         iaddr,
  output logic                    fetch_valid,
  output logic [PC_W-1:0]         fetch_pc,
  output logic [TID_W-1:0]        fetch_tid,
  output logic [NTHREAD*PC_W-1:0] thread_pc,
  output logic                    all_halted
);

  typedef enum logic {IDLE, REQ} seq_state_t;

  seq_state_t       state, state_next;
  logic [PC_W-1:0]  pc [NTHREAD];
  logic [NTHREAD-1:0] run;
  logic [TID_W-1:0] rr, req_tid, sel;
  logic [PC_W-1:0]  sel_pc;
  logic             any_run, issue, complete;
  logic             squash, squash_eff, squash_next, req_hit, sel_hit;

  // With a single thread every tid input is ignored and always names thread 0.
  function automatic logic tid_is(input logic [TID_W-1:0] tid, input int t);
    return (NTHREAD == 1) ? (t == 0) : (int'(tid) == t);
  endfunction

  function automatic logic same_tid(input logic [TID_W-1:0] a, input logic [TID_W-1:0] b);
    return (NTHREAD == 1) ? 1'b1 : (a == b);
  endfunction

  // Round-robin pick: lowest RUN thread at/after rr, else lowest RUN thread overall.
  always_comb begin
    sel     = '0;
    any_run = 1'b0;
    for (int j = NTHREAD - 1; j >= 0; j--) begin
      if (run[j]) begin
        sel     = TID_W'(j);
        any_run = 1'b1;
      end
    end
    for (int j = NTHREAD - 1; j >= 0; j--) begin
      if (run[j] && j >= int'(rr)) sel = TID_W'(j);
    end
    sel_pc = '0;
    for (int t = 0; t < NTHREAD; t++) begin
      if (tid_is(sel, t)) sel_pc = pc[t];
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: if (!stall && any_run) begin
        issue      = 1'b1;
        state_next = REQ;
      end
      REQ: if (ihit && !stall) begin
        complete   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A redirect/halt hitting the thread being issued also squashes, since iaddr carries the stale PC.
  always_comb begin
    req_hit     = (redirect_en && same_tid(redirect_tid, req_tid)) ||
                  (halt_en && same_tid(halt_tid, req_tid));
    sel_hit     = (redirect_en && same_tid(redirect_tid, sel)) ||
                  (halt_en && same_tid(halt_tid, sel));
    squash_eff  = squash || (state == REQ && req_hit);
    squash_next = 1'b0;
    if (issue)         squash_next = sel_hit;
    else if (!complete) squash_next = squash_eff;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int t = 0; t < NTHREAD; t++) begin
        pc[t]  <= PC_W'(PC_INIT + 32'(t) * T_STRIDE);
        run[t] <= 1'b1;
      end
      rr          <= '0;
      req_tid     <= '0;
      squash      <= 1'b0;
      iaddr       <= '0;
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
      fetch_tid   <= '0;
    end else begin
      if (issue) begin
        iaddr   <= sel_pc;
        req_tid <= sel;
      end
      if (complete)
        rr <= (NTHREAD == 1 || int'(req_tid) == NTHREAD - 1) ? '0 : req_tid + 1'b1;
      squash      <= squash_next;
      fetch_valid <= complete && !squash_eff;
      if (complete && !squash_eff) begin
        fetch_pc  <= iaddr;
        fetch_tid <= req_tid;
      end
      for (int t = 0; t < NTHREAD; t++) begin
        if (redirect_en && tid_is(redirect_tid, t))
          pc[t] <= redirect_pc;
        else if (complete && !squash_eff && tid_is(req_tid, t))
          pc[t] <= pc[t] + PC_W'(INCR);
        if (halt_en && tid_is(halt_tid, t))
          run[t] <= 1'b0;
        else if (redirect_en && tid_is(redirect_tid, t))
          run[t] <= 1'b1;
      end
    end
  end

  always_comb begin
    thread_pc = '0;
    for (int t = 0; t < NTHREAD; t++) thread_pc[t*PC_W +: PC_W] = pc[t];
  end

  assign iREN       = (state == REQ);
  assign all_halted = (run == '0) && (state == IDLE);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer (2-thread 32-bit and 1-thread 8-bit wrap)
module tb_pc_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nRST, nRST2, stall, ihit, ihit2;
  logic        redirect_en, redirect_tid, halt_en, halt_tid;
  logic [31:0] redirect_pc;

  logic        iREN, fetch_valid, fetch_tid, all_halted;
  logic [31:0] iaddr, fetch_pc;
  logic [63:0] thread_pc;

  logic        iren2, fv2, ftid2, ah2;
  logic [7:0]  iaddr2, fpc2, tpc2;

  typedef struct packed {
    logic        tid;
    logic [31:0] pc;
  } exp_t;

  exp_t q1[$], q2[$];
  exp_t e1, e2;
  int   vectors = 0, miscompares = 0, fv_count = 0, fv2_count = 0;

  pc_sequencer #(.PC_W(32), .NTHREAD(2), .PC_INIT(0), .T_STRIDE('h1000), .INCR(4)) dut (
    .CLK(CLK), .nRST(nRST), .stall(stall), .ihit(ihit),
    .redirect_en(redirect_en), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
    .halt_en(halt_en), .halt_tid(halt_tid),
    .iREN(iREN), .iaddr(iaddr), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_tid(fetch_tid), .thread_pc(thread_pc), .all_halted(all_halted)
  );

  pc_sequencer #(.PC_W(8), .NTHREAD(1), .PC_INIT('hFC), .T_STRIDE('h1000), .INCR(4)) dut8 (
    .CLK(CLK), .nRST(nRST2), .stall(stall), .ihit(ihit2),
    .redirect_en(redirect_en), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc[7:0]),
    .halt_en(halt_en), .halt_tid(halt_tid),
    .iREN(iren2), .iaddr(iaddr2), .fetch_valid(fv2), .fetch_pc(fpc2),
    .fetch_tid(ftid2), .thread_pc(tpc2), .all_halted(ah2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  always @(negedge CLK) begin
    if (nRST === 1'b1 && fetch_valid === 1'b1) begin
      fv_count++;
      if (q1.size() == 0) check("unexpected_fetch", {32'h0, fetch_pc}, 64'hDEAD);
      else begin
        e1 = q1.pop_front();
        check("fetch_pc", {32'h0, fetch_pc}, {32'h0, e1.pc});
        check("fetch_tid", {63'h0, fetch_tid}, {63'h0, e1.tid});
      end
    end
  end

  always @(negedge CLK) begin
    if (nRST2 === 1'b1 && fv2 === 1'b1) begin
      fv2_count++;
      if (q2.size() == 0) check("unexpected_fetch8", {56'h0, fpc2}, 64'hDEAD);
      else begin
        e2 = q2.pop_front();
        check("fetch_pc8", {56'h0, fpc2}, {32'h0, e2.pc});
      end
    end
  end

  initial begin
    nRST = 1'b1; nRST2 = 1'b1; stall = 1'b0; ihit = 1'b0; ihit2 = 1'b0;
    redirect_en = 1'b0; redirect_tid = 1'b0; redirect_pc = '0; halt_en = 1'b0; halt_tid = 1'b0;
    #2 nRST = 1'b0; nRST2 = 1'b0;
    tick(2);
    check("rst_iren", {63'h0, iREN}, 64'h0);
    check("rst_iaddr", {32'h0, iaddr}, 64'h0);
    check("rst_fv", {63'h0, fetch_valid}, 64'h0);
    check("rst_fetch_pc", {31'h0, fetch_tid, fetch_pc}, 64'h0);
    check("rst_halted", {63'h0, all_halted}, 64'h0);
    check("rst_thread_pc", thread_pc, 64'h0000_1000_0000_0000);
    check("rst_thread_pc8", {56'h0, tpc2}, 64'hFC);

    // Free-running round-robin fetch
    nRST = 1'b1; ihit = 1'b1;
    q1.push_back('{1'b0, 32'h0});    q1.push_back('{1'b1, 32'h1000});
    q1.push_back('{1'b0, 32'h4});    q1.push_back('{1'b1, 32'h1004});
    tick(8);
    ihit = 1'b0;
    tick();
    check("rr_fetch_count", 64'(fv_count), 64'd4);
    check("rr_thread_pc", thread_pc, 64'h0000_1008_0000_0008);
    check("rr_iren", {63'h0, iREN}, 64'h1);
    check("rr_iaddr", {32'h0, iaddr}, 64'h8);

    // Miss held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("miss_iren", {63'h0, iREN}, 64'h1);
      check("miss_iaddr", {32'h0, iaddr}, 64'h8);
      check("miss_pc0", {32'h0, thread_pc[31:0]}, 64'h8);
    end
    check("miss_no_fetch", 64'(fv_count), 64'd4);
    q1.push_back('{1'b0, 32'h8});
    ihit = 1'b1;
    tick();
    ihit = 1'b0;
    check("miss_pc0_after_hit", {32'h0, thread_pc[31:0]}, 64'hC);

    // Redirect t0 while its request is outstanding
    ihit = 1'b1;
    q1.push_back('{1'b1, 32'h1008});
    tick(2);
    ihit = 1'b0;
    tick();
    check("redir_req_iaddr", {32'h0, iaddr}, 64'hC);
    redirect_en = 1'b1; redirect_tid = 1'b0; redirect_pc = 32'h200;
    tick();
    redirect_en = 1'b0;
    tick();
    ihit = 1'b1;
    tick();
    ihit = 1'b0;
    check("redir_pc0", {32'h0, thread_pc[31:0]}, 64'h200);
    ihit = 1'b1;
    q1.push_back('{1'b1, 32'h100C}); q1.push_back('{1'b0, 32'h200});
    tick(4);
    ihit = 1'b0;
    tick();
    check("redir_fetch_count", 64'(fv_count), 64'd8);
    check("redir_iaddr_t1", {32'h0, iaddr}, 64'h1010);

    // Stall with ihit in REQ, then stall in IDLE
    stall = 1'b1; ihit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_iren", {63'h0, iREN}, 64'h1);
      check("stall_pc1", {32'h0, thread_pc[63:32]}, 64'h1010);
    end
    check("stall_no_fetch", 64'(fv_count), 64'd8);
    stall = 1'b0;
    q1.push_back('{1'b1, 32'h1010});
    tick();
    check("stall_release_pc1", {32'h0, thread_pc[63:32]}, 64'h1014);
    stall = 1'b1;
    tick();
    check("stall_idle_iren", {63'h0, iREN}, 64'h0);
    tick();
    check("stall_idle_iren2", {63'h0, iREN}, 64'h0);
    stall = 1'b0; ihit = 1'b0;
    tick();
    check("post_stall_iaddr", {32'h0, iaddr}, 64'h204);

    // Halt both threads, then resume t1 by redirect
    halt_en = 1'b1; halt_tid = 1'b1;
    tick();
    halt_tid = 1'b0;
    tick();
    halt_en = 1'b0; ihit = 1'b1;
    tick(2);
    check("halt_iren", {63'h0, iREN}, 64'h0);
    check("halt_all_halted", {63'h0, all_halted}, 64'h1);
    check("halt_thread_pc", thread_pc, 64'h0000_1014_0000_0204);
    check("halt_fetch_count", 64'(fv_count), 64'd9);
    redirect_en = 1'b1; redirect_tid = 1'b1; redirect_pc = 32'h40;
    q1.push_back('{1'b1, 32'h40});
    tick();
    redirect_en = 1'b0;
    check("resume_all_halted", {63'h0, all_halted}, 64'h0);
    check("resume_pc1", {32'h0, thread_pc[63:32]}, 64'h40);
    tick(2);
    ihit = 1'b0;
    tick();
    check("resume_iaddr", {32'h0, iaddr}, 64'h44);
    check("resume_fetch_count", 64'(fv_count), 64'd10);
    check("resume_pc0_frozen", {32'h0, thread_pc[31:0]}, 64'h204);

    // 8-bit, single-thread wrap and reset mid-request
    nRST2 = 1'b1; ihit2 = 1'b1;
    q2.push_back('{1'b0, 32'hFC}); q2.push_back('{1'b0, 32'h00});
    tick(4);
    ihit2 = 1'b0;
    tick();
    check("wrap_fetch_count", 64'(fv2_count), 64'd2);
    check("wrap_iren", {63'h0, iren2}, 64'h1);
    check("wrap_iaddr", {56'h0, iaddr2}, 64'h04);
    #2 nRST2 = 1'b0;
    #1;
    check("rst_mid_iren", {63'h0, iren2}, 64'h0);
    check("rst_mid_iaddr", {56'h0, iaddr2}, 64'h0);
    check("rst_mid_fv", {63'h0, fv2}, 64'h0);
    check("rst_mid_pc", {56'h0, tpc2}, 64'hFC);
    tick(3);

    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
